// File: rtl/reset_sequencer_pkg.sv
// Shared types and helpers for the reset sequencer.
//   seq_state_e : sequencer states (Assert=0, Release=1, Run=2)
//   cnt_width() : width of a counter that must hold values up to (largest count - 1)
package reset_sequencer_pkg;

  typedef enum logic [1:0] {
    StAssert  = 2'd0,
    StRelease = 2'd1,
    StRun     = 2'd2
  } seq_state_e;

  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b,
                                            input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/reset_sequencer_sync_debounce.sv
// Two-flop synchronizer followed by a debounce counter. Reusable for any push button.
// The debounced level only moves after the synchronized input has disagreed with it for
// DEBOUNCE_CYCLES consecutive cycles; any agreeing cycle restarts the count.
// Ports:
//   CLK_100MHz in  clock
//   RESET      in  asynchronous active-high reset (clears all flops)
//   in         in  raw asynchronous, possibly bouncy input
//   out        out debounced level
module sync_debounce
  import reset_sequencer_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000,
  parameter int unsigned CNT_W           = cnt_width(DEBOUNCE_CYCLES, 1, 1)
) (
  input  logic CLK_100MHz,
  input  logic RESET,
  input  logic in,
  output logic out
);

  localparam logic [CNT_W-1:0] DbLast = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge CLK_100MHz or posedge RESET) begin
    if (RESET) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= in;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      // The edge that would make the count reach DEBOUNCE_CYCLES flips the level instead.
      if (cnt_q == DbLast) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  assign out = level_q;

endmodule

// File: rtl/reset_sequencer.sv
// Staged reset sequencer: turns RESET, a debounced push button and (optionally) a watchdog
// into ordered synchronous reset releases (bit 0 first) and a READY flag.
// Optional feature macro: RESET_WATCHDOG_EN (watchdog re-sequence and sticky WDT_FIRED).
// Ports:
//   CLK_100MHz in  system clock
//   RESET      in  asynchronous active-high reset
//   BUTTON     in  asynchronous active-high reset request (bouncy)
//   WDT_KICK   in  one-cycle watchdog kick (ignored without RESET_WATCHDOG_EN)
//   RST_OUT    out STAGES staged active-high resets
//   READY      out high in RUN, once every stage is released
//   WDT_FIRED  out sticky: watchdog expiry caused a re-sequence
module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int unsigned STAGES          = 3,
  parameter int unsigned HOLD_CYCLES     = 16,
  parameter int unsigned STAGE_GAP       = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 1000,
  parameter int unsigned WDT_TIMEOUT     = 65536
) (
  input  logic              CLK_100MHz,
  input  logic              RESET,
  input  logic              BUTTON,
  input  logic              WDT_KICK,
  output logic [STAGES-1:0] RST_OUT,
  output logic              READY,
  output logic              WDT_FIRED
);

  localparam int unsigned CntW = cnt_width(HOLD_CYCLES, STAGE_GAP, DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0] HoldLast = CntW'(HOLD_CYCLES - 1);
  localparam logic [CntW-1:0] GapLast  = CntW'(STAGE_GAP - 1);

  logic btn_level;
  logic wdt_expire;
  logic req;

  sync_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CntW)
  ) u_button (
    .CLK_100MHz(CLK_100MHz),
    .RESET     (RESET),
    .in        (BUTTON),
    .out       (btn_level)
  );

  assign req = btn_level | wdt_expire;

  seq_state_e        state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  // Stages still held in reset; bits are cleared from the bottom up by shifting left.
  logic [STAGES-1:0] mask_q, mask_d;

  always_ff @(posedge CLK_100MHz or posedge RESET) begin
    if (RESET) begin
      state_q <= StAssert;
      cnt_q   <= '0;
      mask_q  <= '1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mask_d  = mask_q;
    if (req) begin
      state_d = StAssert;
      cnt_d   = '0;
      mask_d  = '1;
    end else begin
      unique case (state_q)
        StAssert: begin
          if (cnt_q == HoldLast) begin
            state_d = StRelease;
            cnt_d   = '0;
            mask_d  = mask_q << 1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        StRelease: begin
          if (mask_q == '0) begin
            state_d = StRun;
            cnt_d   = '0;
          end else if (cnt_q == GapLast) begin
            cnt_d  = '0;
            mask_d = mask_q << 1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        StRun: begin
          cnt_d = '0;
        end
        default: begin
          state_d = StAssert;
          cnt_d   = '0;
          mask_d  = '1;
        end
      endcase
    end
  end

  always_comb begin
    RST_OUT = '1;
    READY   = 1'b0;
    unique case (state_q)
      StRelease: RST_OUT = mask_q;
      StRun: begin
        RST_OUT = '0;
        READY   = 1'b1;
      end
      default: begin
        RST_OUT = '1;
        READY   = 1'b0;
      end
    endcase
  end

`ifdef RESET_WATCHDOG_EN
  localparam int unsigned WdtW = (WDT_TIMEOUT > 1) ? $clog2(WDT_TIMEOUT) : 1;
  localparam logic [WdtW-1:0] WdtLast = WdtW'(WDT_TIMEOUT - 1);

  logic [WdtW-1:0] wdt_q, wdt_d;
  logic            fired_q, fired_d;

  always_ff @(posedge CLK_100MHz or posedge RESET) begin
    if (RESET) begin
      wdt_q   <= '0;
      fired_q <= 1'b0;
    end else begin
      wdt_q   <= wdt_d;
      fired_q <= fired_d;
    end
  end

  // A kick on the expiry edge suppresses the expiry.
  assign wdt_expire = (state_q == StRun) && !WDT_KICK && (wdt_q == WdtLast);

  always_comb begin
    wdt_d   = '0;
    fired_d = fired_q | wdt_expire;
    if ((state_q == StRun) && (state_d == StRun) && !WDT_KICK) begin
      wdt_d = wdt_q + 1'b1;
    end
  end

  assign WDT_FIRED = fired_q;
`else
  logic unused_wdt_kick;
  assign unused_wdt_kick = WDT_KICK;
  assign wdt_expire      = 1'b0;
  assign WDT_FIRED       = 1'b0;
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: a 3-stage and a 1-stage instance share stimulus; a timeline
// model (edges since the last reset cause) predicts every output each cycle.
module tb_reset_sequencer;

  localparam int unsigned H = 4;
  localparam int unsigned G = 2;
  localparam int unsigned D = 5;
  localparam int unsigned T = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       button = 1'b0;
  logic       kick = 1'b0;
  logic [2:0] rst_out3;
  logic       rdy3, fired3;
  logic [0:0] rst_out1;
  logic       rdy1, fired1;

  always #5 clk = ~clk;

  reset_sequencer #(
    .STAGES(3), .HOLD_CYCLES(H), .STAGE_GAP(G), .DEBOUNCE_CYCLES(D), .WDT_TIMEOUT(T)
  ) u_dut3 (
    .CLK_100MHz(clk), .RESET(rst), .BUTTON(button), .WDT_KICK(kick),
    .RST_OUT(rst_out3), .READY(rdy3), .WDT_FIRED(fired3)
  );

  reset_sequencer #(
    .STAGES(1), .HOLD_CYCLES(H), .STAGE_GAP(G), .DEBOUNCE_CYCLES(D), .WDT_TIMEOUT(T)
  ) u_dut1 (
    .CLK_100MHz(clk), .RESET(rst), .BUTTON(button), .WDT_KICK(kick),
    .RST_OUT(rst_out1), .READY(rdy1), .WDT_FIRED(fired1)
  );

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  // Button: synced value is the input two edges late; level flips when the last D synced
  // samples all disagree with it. Sequencer: every output is a threshold on the number of
  // edges since a reset cause was last seen.
  bit m_s1;
  bit m_syn[$];
  bit m_level;
  int m_since[2];
  int m_idle[2];
  bit m_fired[2];

  function automatic int stages_of(input int k);
    return (k == 0) ? 3 : 1;
  endfunction

  function automatic bit model_ready(input int k);
    return m_since[k] >= int'(H) + (stages_of(k) - 1) * int'(G) + 1;
  endfunction

  function automatic logic [2:0] model_rst(input int k);
    logic [2:0] r;
    r = '0;
    for (int i = 0; i < stages_of(k); i++) r[i] = (m_since[k] < int'(H) + i * int'(G));
    return r;
  endfunction

  always @(posedge clk or posedge rst) begin
    bit flip;
    bit expire;
    bit rdy_pre;
    if (rst) begin
      m_s1 = 1'b0;
      m_syn.delete();
      m_level = 1'b0;
      for (int k = 0; k < 2; k++) begin
        m_since[k] = 0;
        m_idle[k]  = 0;
        m_fired[k] = 1'b0;
      end
    end else begin
      flip = (m_syn.size() >= int'(D));
      for (int d = 0; d < int'(D) && flip; d++) begin
        if (m_syn[m_syn.size() - 1 - d] == m_level) flip = 1'b0;
      end
      for (int k = 0; k < 2; k++) begin
        rdy_pre = model_ready(k);
        expire  = 1'b0;
`ifdef RESET_WATCHDOG_EN
        if (!rdy_pre || kick) m_idle[k] = 0;
        else if (m_idle[k] == int'(T) - 1) begin
          expire     = 1'b1;
          m_fired[k] = 1'b1;
        end else m_idle[k]++;
`else
        m_idle[k] = rdy_pre ? m_idle[k] + 1 : 0;
`endif
        if (m_level || expire) m_since[k] = 0;
        else if (m_since[k] < 1000) m_since[k]++;
      end
      if (flip) m_level = !m_level;
      m_syn.push_back(m_s1);
      if (m_syn.size() > 64) void'(m_syn.pop_front());
      m_s1 = button;
    end
  end

  // ---------------- per-cycle compare ----------------
  bit cmp_en = 1'b0;

  always @(negedge clk) begin
    logic [2:0] e3;
    logic [2:0] e1;
    if (cmp_en) begin
      e3 = model_rst(0);
      e1 = model_rst(1);
      check("model rst_out3", 32'(rst_out3), 32'(e3));
      check("model ready3", 32'(rdy3), 32'(model_ready(0)));
      check("model fired3", 32'(fired3), 32'(m_fired[0]));
      check("model rst_out1", 32'(rst_out1), 32'(e1[0]));
      check("model ready1", 32'(rdy1), 32'(model_ready(1)));
      check("model fired1", 32'(fired1), 32'(m_fired[1]));
    end
  end

  // ---------------- kick generator ----------------
  int kick_period = 3;
  int kick_ph = 0;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      kick_ph++;
      kick = (kick_period != 0) && (kick_ph % kick_period == 0);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (rdy3 !== 1'b1 && n < 200) begin
      tick(1);
      n++;
    end
    check(name, 32'(rdy3), 32'h1);
  endtask

  int bounce_lvl[10] = '{1, 0, 1, 0, 1, 0, 1, 0, 1, 0};
  int bounce_len[10] = '{2, 1, 4, 2, 6, 3, 1, 1, 5, 9};

  initial begin
    tick(3);
    cmp_en = 1'b1;
    check("reset rst_out3", 32'(rst_out3), 32'h7);
    check("reset ready3", 32'(rdy3), 32'h0);
    check("reset fired3", 32'(fired3), 32'h0);
    check("reset rst_out1", 32'(rst_out1), 32'h1);

    // Release from power-up reset: bit0@4, bit1@6, bit2@8, READY@9; 1-stage: 4 and 5.
    rst = 1'b0;
    tick(3);
    check("e3 rst_out3", 32'(rst_out3), 32'h7);
    tick(1);
    check("e4 rst_out3", 32'(rst_out3), 32'h6);
    check("e4 rst_out1", 32'(rst_out1), 32'h0);
    check("e4 ready1", 32'(rdy1), 32'h0);
    tick(1);
    check("e5 ready1", 32'(rdy1), 32'h1);
    check("e5 rst_out3", 32'(rst_out3), 32'h6);
    tick(1);
    check("e6 rst_out3", 32'(rst_out3), 32'h4);
    tick(2);
    check("e8 rst_out3", 32'(rst_out3), 32'h0);
    check("e8 ready3", 32'(rdy3), 32'h0);
    tick(1);
    check("e9 ready3", 32'(rdy3), 32'h1);

    // Short press is filtered out.
    button = 1'b1;
    tick(3);
    button = 1'b0;
    tick(12);
    check("short press ready3", 32'(rdy3), 32'h1);

    // 8-cycle press: debounced rise at edge 7, re-sequence at edge 8.
    button = 1'b1;
    tick(7);
    check("press e7 ready3", 32'(rdy3), 32'h1);
    tick(1);
    check("press e8 rst_out3", 32'(rst_out3), 32'h7);
    check("press e8 ready3", 32'(rdy3), 32'h0);
    button = 1'b0;
    tick(10);
    check("press hold rst_out3", 32'(rst_out3), 32'h7);
    tick(1);
    check("press bit0 rst_out3", 32'(rst_out3), 32'h6);

    // Async RESET mid-release takes effect before the next edge.
    #2;
    rst = 1'b1;
    #1;
    check("async rst_out3", 32'(rst_out3), 32'h7);
    check("async ready3", 32'(rdy3), 32'h0);
    check("async rst_out1", 32'(rst_out1), 32'h1);
    tick(2);
    rst = 1'b0;
    wait_ready("ready after async reset");

    // Long press: held in ASSERT; bit0 falls 4 edges after the debounced fall.
    button = 1'b1;
    tick(100);
    check("long press rst_out3", 32'(rst_out3), 32'h7);
    check("long press ready3", 32'(rdy3), 32'h0);
    button = 1'b0;
    tick(10);
    check("long release rst_out3", 32'(rst_out3), 32'h7);
    tick(1);
    check("long release bit0", 32'(rst_out3), 32'h6);
    wait_ready("ready after long press");

    // Bouncy input, checked by the per-cycle model.
    for (int i = 0; i < 10; i++) begin
      button = bounce_lvl[i][0];
      tick(bounce_len[i]);
    end
    button = 1'b0;
    wait_ready("ready after bounce");

`ifdef RESET_WATCHDOG_EN
    kick_period = 0;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    wait_ready("wdt run entry");
    tick(9);
    check("wdt e9 ready3", 32'(rdy3), 32'h1);
    check("wdt e9 fired3", 32'(fired3), 32'h0);
    tick(1);
    check("wdt e10 ready3", 32'(rdy3), 32'h0);
    check("wdt e10 rst_out3", 32'(rst_out3), 32'h7);
    check("wdt e10 fired3", 32'(fired3), 32'h1);
    kick_period = 5;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    wait_ready("wdt kicked entry");
    tick(40);
    check("wdt kicked ready3", 32'(rdy3), 32'h1);
    check("wdt kicked fired3", 32'(fired3), 32'h0);
`else
    kick_period = 0;
    tick(40);
    check("no wdt ready3", 32'(rdy3), 32'h1);
    check("no wdt fired3", 32'(fired3), 32'h0);
    check("no wdt fired1", 32'(fired1), 32'h0);
    kick_period = 1;
    tick(5);
    check("kick ignored ready3", 32'(rdy3), 32'h1);
`endif

    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, checks=%0d", n_checks);
    $fatal(1);
  end

endmodule
